// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } cmp_state_t;

  typedef enum logic [1:0] {
    RES_EQ,
    RES_GT,
    RES_LT
  } cmp_res_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index over n slices; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_chunk_cmp.sv
// Combinational compare of one operand slice, signed or unsigned.
module mag_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice_a,
  input  logic [CHUNK-1:0] slice_b,
  input  logic             is_signed,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic w_gt_u;
  logic w_gt_s;

  assign w_gt_u = (slice_a > slice_b);
  assign w_gt_s = ($signed(slice_a) > $signed(slice_b));

  assign eq = (slice_a == slice_b);
  assign gt = is_signed ? w_gt_s : w_gt_u;
  assign lt = ~eq & ~gt;

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: walks operand slices MSB-first and stops
// at the first slice that differs.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                signed_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                aeqb,
  output logic                                agtb,
  output logic                                altb,
  output logic [cnt_w(WIDTH/CHUNK)-1:0]       chunks
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  localparam int IW     = idx_w(NCHUNK);

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  cmp_res_t         r_res;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic             w_top;
  logic             w_last;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;

  // Slice mux: a constant-bounded loop avoids a variable-width multiply.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IW'(i)) begin
        w_sa = r_a[i*CHUNK +: CHUNK];
        w_sb = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_top  = (r_idx == IW'(NCHUNK - 1));
  assign w_last = (r_idx == '0);

  // Only the top slice carries the sign; lower slices are plain magnitudes.
  mag_chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_cmp (
    .slice_a  (w_sa),
    .slice_b  (w_sb),
    .is_signed(r_sgn & w_top),
    .eq       (w_eq),
    .gt       (w_gt),
    .lt       (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nxt = CMP;
        CMP:     if (!w_eq || w_last) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
      r_res <= RES_EQ;
    end else if (clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
      r_res <= RES_EQ;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_sgn <= signed_mode;
            r_idx <= IW'(NCHUNK - 1);
            r_cnt <= '0;
          end
        end
        CMP: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_gt && !w_eq) begin
            r_res <= RES_GT;
          end else if (w_lt) begin
            r_res <= RES_LT;
          end else if (w_last) begin
            r_res <= RES_EQ;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign aeqb      = out_valid && (r_res == RES_EQ);
  assign agtb      = out_valid && (r_res == RES_GT);
  assign altb      = out_valid && (r_res == RES_LT);
  assign chunks    = r_cnt;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: directed and random operations on a 32/8 and a 16/16 instance.
module tb_seq_mag_comp;

  logic        clk = 1'b0;
  logic        rst_n, clr, sm, ordy, iv1, iv2, sel;
  logic [31:0] a, b;

  logic        ir1, ov1, eq1, gt1, lt1;
  logic [2:0]  ch1;
  logic        ir2, ov2, eq2, gt2, lt2;
  logic [0:0]  ch2;

  logic        ir, ov, eq, gt, lt;
  logic [2:0]  ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mag_comp #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .signed_mode(sm), .out_valid(ov1), .out_ready(ordy),
    .aeqb(eq1), .agtb(gt1), .altb(lt1), .chunks(ch1)
  );

  seq_mag_comp #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv2), .in_ready(ir2),
    .a(a[15:0]), .b(b[15:0]), .signed_mode(sm), .out_valid(ov2), .out_ready(ordy),
    .aeqb(eq2), .agtb(gt2), .altb(lt2), .chunks(ch2)
  );

  always_comb begin
    if (sel) {ir, ov, eq, gt, lt, ch} = {ir2, ov2, eq2, gt2, lt2, 2'b00, ch2};
    else     {ir, ov, eq, gt, lt, ch} = {ir1, ov1, eq1, gt1, lt1, ch1};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic compare; slices examined = slices down to
  // and including the one holding the highest differing bit.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic s,
                       input int w, input int c, output logic [2:0] res, output int k);
    logic signed [63:0] xa, xb;
    logic [31:0] mask, d;
    bit found;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xa = $signed({32'b0, ma & mask});
    xb = $signed({32'b0, mb & mask});
    if (s && ma[w-1]) xa = xa - (64'sd1 <<< w);
    if (s && mb[w-1]) xb = xb - (64'sd1 <<< w);
    res = (xa == xb) ? 3'b100 : (xa > xb) ? 3'b010 : 3'b001;
    d = (ma ^ mb) & mask;
    k = w / c;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] && !found) begin
        k = (w / c) - i / c;
        found = 1'b1;
      end
    end
  endtask

  task automatic run_op(input logic s1, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input int hold);
    logic [2:0] res;
    int k, lat, w, c;
    w = s1 ? 16 : 32;
    c = s1 ? 16 : 8;
    sel = s1;
    model(ta, tb_, ts, w, c, res, k);
    #0;
    chk("idle_in_ready", 64'(ir), 64'(1));
    a = ta; b = tb_; sm = ts;
    if (s1) iv2 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    a = $urandom; b = $urandom; sm = ~ts;
    lat = 1;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(k + 1));
    chk("result", 64'({eq, gt, lt}), 64'(res));
    chk("chunks", 64'(ch), 64'(k));
    for (int h = 0; h < hold; h++) begin
      if (s1) iv2 = 1'b1; else iv1 = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_stable", 64'({ov, ir, eq, gt, lt, ch}), 64'({1'b1, 1'b0, res, 3'(k)}));
    end
    iv1 = 1'b0; iv2 = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("release", 64'({ov, ir, eq, gt, lt}), 64'(5'b01000));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lat;
    logic [31:0] ra, rb;
    rst_n = 1'b0; clr = 1'b0; iv1 = 1'b0; iv2 = 1'b0; ordy = 1'b0;
    sel = 1'b0; sm = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_1", 64'({ir1, ov1, eq1, gt1, lt1, ch1}), 64'({5'b10000, 3'd0}));
    chk("reset_2", 64'({ir2, ov2, eq2, gt2, lt2, ch2}), 64'(6'b100000));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
    run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    run_op(1'b0, 32'h1234_0000, 32'h1235_0000, 1'b0, 0);
    run_op(1'b0, 32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 0);
    run_op(1'b0, 32'hCAFE_BABE, 32'hCAFE_0000, 1'b0, 3);

    // Abort with clr while slice 2 is being compared; same-cycle in_valid is dropped.
    sel = 1'b0;
    a = 32'h1234_5678; b = 32'h1234_5678; sm = 1'b0;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; iv1 = 1'b0;
    chk("clr_outputs", 64'({ov1, ir1, eq1, gt1, lt1, ch1}), 64'({5'b01000, 3'd0}));
    @(posedge clk); #1;
    chk("clr_no_accept", 64'({ov1, ir1}), 64'(2'b01));

    // Asynchronous reset while a result is waiting.
    a = 32'h1; b = 32'h2; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("pre_rst_done", 64'({ov1, lt1}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({ov1, ir1, eq1, gt1, lt1, ch1}), 64'({5'b01000, 3'd0}));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst", 64'({ov1, ir1, eq1, gt1, lt1}), 64'(5'b01000));

    run_op(1'b0, 32'd5, 32'd3, 1'b0, 0);
    run_op(1'b1, 32'h0000_8000, 32'h0000_0001, 1'b1, 0);
    run_op(1'b1, 32'h0000_8000, 32'h0000_0001, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ra ^ ($urandom & (32'hFFFF_FFFF >> ($urandom % 32)));
      if ($urandom % 5 == 0) rb = ra;
      run_op(($urandom % 4) == 0, ra, rb, 1'($urandom), int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
